// File: rtl/stream_upsizer.sv
// stream_upsizer
// Packs RATIO consecutive DATA_WIDTH-bit valid/ready beats into one
// DATA_WIDTH*RATIO-bit word, lane 0 in the LSBs. A beat with last_s closes
// the word early; keep_m marks which lanes hold real data.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_s/ready_s     narrow input handshake
//   data_s, last_s      input beat and end-of-packet flag
//   valid_m/ready_m     wide output handshake (valid_m registered)
//   data_m              packed word, lane k = data_m[k*DATA_WIDTH +: DATA_WIDTH]
//   keep_m, last_m      per-lane valid mask and end-of-packet flag (registered)
module stream_upsizer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_s,
  output logic                        ready_s,
  input  logic [DATA_WIDTH-1:0]       data_s,
  input  logic                        last_s,
  output logic                        valid_m,
  input  logic                        ready_m,
  output logic [DATA_WIDTH*RATIO-1:0] data_m,
  output logic [RATIO-1:0]            keep_m,
  output logic                        last_m
);

  localparam int CW = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam int AW = DATA_WIDTH * (RATIO - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  logic [CW-1:0]               cnt;
  logic [AW-1:0]               acc;
  logic [DATA_WIDTH*RATIO-1:0] acc_ext;
  logic [DATA_WIDTH*RATIO-1:0] word_next;
  logic [RATIO-1:0]            keep_next;
  logic                        write;
  logic                        read;
  logic                        complete;

  // The output register can take a new word whenever it is empty or being
  // drained this cycle, so a completing beat never waits for a bubble.
  assign ready_s  = !valid_m || ready_m;
  assign write    = valid_s && ready_s;
  assign read     = valid_m && ready_m;
  assign complete = last_s || (cnt == CNT_MAX);

  // Pad the accumulator to full word width so every lane index is in range.
  assign acc_ext = {{DATA_WIDTH{1'b0}}, acc};

  // Lanes below cnt come from the accumulator, lane cnt is the incoming
  // beat, lanes above cnt are zero.
  always_comb begin
    word_next = '0;
    keep_next = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k < int'(cnt)) begin
        word_next[k*DATA_WIDTH +: DATA_WIDTH] = acc_ext[k*DATA_WIDTH +: DATA_WIDTH];
        keep_next[k] = 1'b1;
      end else if (k == int'(cnt)) begin
        word_next[k*DATA_WIDTH +: DATA_WIDTH] = data_s;
        keep_next[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      valid_m <= 1'b0;
      keep_m  <= '0;
      last_m  <= 1'b0;
    end else if (write && complete) begin
      cnt     <= '0;
      valid_m <= 1'b1;
      keep_m  <= keep_next;
      last_m  <= last_s;
    end else begin
      if (read) valid_m <= 1'b0;
      if (write) cnt <= cnt + CW'(1);
    end
  end

  // Payload storage carries no reset; it is only meaningful under valid_m.
  always_ff @(posedge clk) begin
    if (!rst && write && complete) data_m <= word_next;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (write && !complete && cnt == CW'(k))
        acc[k*DATA_WIDTH +: DATA_WIDTH] <= data_s;
    end
  end

endmodule

// File: tb/tb_stream_upsizer.sv
// Testbench for stream_upsizer: directed scenarios on a RATIO=4 instance and
// a randomized scoreboard run on a RATIO=3 instance.
module tb_stream_upsizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v_s = 1'b0, r_s, l_s = 1'b0, v_m, r_m = 1'b1, l_m;
  logic [7:0]  d_s = '0;
  logic [31:0] d_m;
  logic [3:0]  k_m;

  logic        v3_s = 1'b0, r3_s, l3_s = 1'b0, v3_m, r3_m = 1'b1, l3_m;
  logic [7:0]  d3_s = '0;
  logic [23:0] d3_m;
  logic [2:0]  k3_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stream_upsizer #(.DATA_WIDTH(8), .RATIO(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .valid_s(v_s), .ready_s(r_s), .data_s(d_s), .last_s(l_s),
    .valid_m(v_m), .ready_m(r_m), .data_m(d_m), .keep_m(k_m), .last_m(l_m)
  );

  stream_upsizer #(.DATA_WIDTH(8), .RATIO(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .valid_s(v3_s), .ready_s(r3_s), .data_s(d3_s), .last_s(l3_s),
    .valid_m(v3_m), .ready_m(r3_m), .data_m(d3_m), .keep_m(k3_m), .last_m(l3_m)
  );

  // Inputs change on the falling edge; samples are taken 1 time unit later.
  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic rm);
    @(negedge clk);
    v_s = v; d_s = d; l_s = l; r_m = rm;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    n_tests++; if (v_m !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", v_m); end
    n_tests++; if (k_m !== 4'h0) begin n_fail++; $display("FAIL reset_keep got %h exp 0", k_m); end
    n_tests++; if (l_m !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b exp 0", l_m); end
    n_tests++; if (r_s !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", r_s); end
  endtask

  task automatic test_full_words;
    logic [7:0] beats [8];
    beats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, beats[i], 1'b0, 1'b1);
      n_tests++; if (r_s !== 1'b1) begin n_fail++; $display("FAIL full_ready beat %0d got %b exp 1", i, r_s); end
      n_tests++;
      if (v_m !== (i == 4)) begin n_fail++; $display("FAIL full_valid beat %0d got %b exp %b", i, v_m, (i == 4)); end
      if (i == 4) begin
        n_tests++; if (d_m !== 32'h44332211) begin n_fail++; $display("FAIL full_data1 got %h exp 44332211", d_m); end
        n_tests++; if (k_m !== 4'hF) begin n_fail++; $display("FAIL full_keep1 got %h exp f", k_m); end
        n_tests++; if (l_m !== 1'b0) begin n_fail++; $display("FAIL full_last1 got %b exp 0", l_m); end
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_tests++; if (v_m !== 1'b1) begin n_fail++; $display("FAIL full_valid2 got %b exp 1", v_m); end
    n_tests++; if (d_m !== 32'h88776655) begin n_fail++; $display("FAIL full_data2 got %h exp 88776655", d_m); end
    n_tests++; if (k_m !== 4'hF) begin n_fail++; $display("FAIL full_keep2 got %h exp f", k_m); end
    n_tests++; if (l_m !== 1'b0) begin n_fail++; $display("FAIL full_last2 got %b exp 0", l_m); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_tests++; if (v_m !== 1'b0) begin n_fail++; $display("FAIL full_drain got %b exp 0", v_m); end
  endtask

  task automatic test_short_packet;
    drive(1'b1, 8'hA1, 1'b0, 1'b1);
    drive(1'b1, 8'hA2, 1'b1, 1'b1);
    drive(1'b1, 8'hB1, 1'b0, 1'b1);
    n_tests++; if (v_m !== 1'b1) begin n_fail++; $display("FAIL short_valid got %b exp 1", v_m); end
    n_tests++; if (d_m !== 32'h0000A2A1) begin n_fail++; $display("FAIL short_data got %h exp 0000a2a1", d_m); end
    n_tests++; if (k_m !== 4'h3) begin n_fail++; $display("FAIL short_keep got %h exp 3", k_m); end
    n_tests++; if (l_m !== 1'b1) begin n_fail++; $display("FAIL short_last got %b exp 1", l_m); end
    drive(1'b1, 8'hB2, 1'b0, 1'b1);
    drive(1'b1, 8'hB3, 1'b0, 1'b1);
    drive(1'b1, 8'hB4, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_tests++; if (d_m !== 32'hB4B3B2B1) begin n_fail++; $display("FAIL short_next_data got %h exp b4b3b2b1", d_m); end
    n_tests++; if (k_m !== 4'hF) begin n_fail++; $display("FAIL short_next_keep got %h exp f", k_m); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_single_beat;
    drive(1'b1, 8'h5A, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_tests++; if (v_m !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", v_m); end
    n_tests++; if (d_m !== 32'h0000005A) begin n_fail++; $display("FAIL single_data got %h exp 0000005a", d_m); end
    n_tests++; if (k_m !== 4'h1) begin n_fail++; $display("FAIL single_keep got %h exp 1", k_m); end
    n_tests++; if (l_m !== 1'b1) begin n_fail++; $display("FAIL single_last got %b exp 1", l_m); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_tests++; if (v_m !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b exp 0", v_m); end
  endtask

  task automatic test_backpressure;
    drive(1'b1, 8'h01, 1'b0, 1'b1);
    drive(1'b1, 8'h02, 1'b0, 1'b1);
    drive(1'b1, 8'h03, 1'b0, 1'b1);
    drive(1'b1, 8'h04, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h09, 1'b1, 1'b0);
      n_tests++; if (r_s !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc %0d got %b exp 0", i, r_s); end
      n_tests++; if (v_m !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc %0d got %b exp 1", i, v_m); end
      n_tests++; if (d_m !== 32'h04030201) begin n_fail++; $display("FAIL bp_data cyc %0d got %h exp 04030201", i, d_m); end
      n_tests++; if (k_m !== 4'hF) begin n_fail++; $display("FAIL bp_keep cyc %0d got %h exp f", i, k_m); end
    end
    drive(1'b1, 8'h09, 1'b1, 1'b1);
    n_tests++; if (r_s !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", r_s); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_tests++; if (v_m !== 1'b1) begin n_fail++; $display("FAIL bp_reload_valid got %b exp 1", v_m); end
    n_tests++; if (d_m !== 32'h00000009) begin n_fail++; $display("FAIL bp_reload_data got %h exp 00000009", d_m); end
    n_tests++; if (k_m !== 4'h1) begin n_fail++; $display("FAIL bp_reload_keep got %h exp 1", k_m); end
    n_tests++; if (l_m !== 1'b1) begin n_fail++; $display("FAIL bp_reload_last got %b exp 1", l_m); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_tests++; if (v_m !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b exp 0", v_m); end
  endtask

  task automatic test_reset_mid_packet;
    logic [7:0] beats [4];
    beats = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    drive(1'b1, 8'hE1, 1'b0, 1'b1);
    drive(1'b1, 8'hE2, 1'b0, 1'b1);
    drive(1'b1, 8'hE3, 1'b0, 1'b1);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, beats[i], 1'b0, 1'b1);
      n_tests++; if (v_m !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_word beat %0d got %b exp 0", i, v_m); end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_tests++; if (v_m !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid got %b exp 1", v_m); end
    n_tests++; if (d_m !== 32'hC4C3C2C1) begin n_fail++; $display("FAIL rstmid_data got %h exp c4c3c2c1", d_m); end
    n_tests++; if (k_m !== 4'hF) begin n_fail++; $display("FAIL rstmid_keep got %h exp f", k_m); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  typedef struct packed {
    logic        last;
    logic [2:0]  keep;
    logic [23:0] data;
  } w3_t;

  task automatic test_random_ratio3;
    w3_t         exp_q [$];
    w3_t         exp_w;
    w3_t         held;
    logic        hold = 1'b0;
    logic        rd, wr;
    logic [23:0] mw = '0;
    logic [2:0]  mk = '0;
    int          mc = 0;
    for (int i = 0; i < 420; i++) begin
      @(negedge clk);
      if (hold) begin
        n_tests++;
        if (v3_m !== 1'b1 || {l3_m, k3_m, d3_m} !== held) begin
          n_fail++; $display("FAIL rnd_hold cyc %0d got v=%b %h exp v=1 %h", i, v3_m, {l3_m, k3_m, d3_m}, held);
        end
      end
      if (i < 400) begin
        v3_s = ($urandom_range(0, 3) != 0);
        r3_m = ($urandom_range(0, 3) != 0);
        l3_s = ($urandom_range(0, 4) == 0);
        d3_s = 8'($urandom);
      end else begin
        v3_s = 1'b0; r3_m = 1'b1; l3_s = 1'b0;
      end
      #1;
      n_tests++;
      if (r3_s !== (!v3_m || r3_m)) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, r3_s, (!v3_m || r3_m)); end
      rd   = v3_m && r3_m;
      wr   = v3_s && r3_s;
      hold = v3_m && !r3_m;
      held = {l3_m, k3_m, d3_m};
      if (rd) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_unexpected_word cyc %0d got %h exp none", i, held);
        end else begin
          exp_w = exp_q.pop_front();
          if (held !== exp_w) begin n_fail++; $display("FAIL rnd_word cyc %0d got %h exp %h", i, held, exp_w); end
        end
      end
      if (wr) begin
        mw[mc*8 +: 8] = d3_s;
        mk[mc] = 1'b1;
        mc++;
        if (mc == 3 || l3_s) begin
          exp_q.push_back({l3_s, mk, mw});
          mw = '0; mk = '0; mc = 0;
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_missing_words got %0d left exp 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_short_packet();
    test_single_beat();
    test_backpressure();
    test_reset_mid_packet();
    test_random_ratio3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
